// File: rtl/vga_pkg.sv
// Default 640x480@60 raster constants and the pixel colour type shared by the VGA
// timing generator and its users.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CW       = 4;
  localparam int DEF_CNT_W    = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [3*DEF_CW-1:0] rgb_t;

endpackage

// File: rtl/pix_tick_gen.sv
// Divides the system clock down to a one-clk-wide pixel tick every CLK_DIV cycles.
// The tick stays low while en is low and until the first clock after reset.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          armed;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (!en || div == LAST) div <= '0;
      else                    div <= div + 1'b1;
    end
  end

  // armed keeps a CLK_DIV=1 tick (div always equals LAST) quiet while in reset.
  assign tick = en && armed && (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters advance on each pixel tick, and a
// one-tick output stage registers sync, display enable and blanked colour together.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CW       = DEF_CW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  output logic            req_valid,
  input  logic [3*CW-1:0] rgb_in,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [3*CW-1:0] rgb_out,
  output logic            frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             tick;
  logic [CNT_W-1:0] h, v;
  logic             active, hs_on, vs_on;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick)
  );

  // Stage 0: raster position of the pixel being requested from the renderer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (!en) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign active    = (h < H_ACT) && (v < V_ACT);
  assign hs_on     = (h >= HS_START) && (h < HS_END);
  assign vs_on     = (v >= VS_START) && (v < VS_END);
  assign req_x     = h;
  assign req_y     = v;
  assign req_valid = tick && active;

  // Stage 1: everything the DAC sees is registered on the same tick, so it is skew-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (h == '0) && (v == '0);
      if (tick) begin
        de      <= active;
        rgb_out <= active ? rgb_in : '0;
        hsync   <= hs_on ? HS_POL : ~HS_POL;
        vsync   <= vs_on ? VS_POL : ~VS_POL;
      end
    end
  end

endmodule
